id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, number of cycles a multiply (ALU_control 3) occupies EX; legal range 1-15.
REQ-002 SHALL use one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  synchronous active-low reset.
REQ-003 SHALL have inputs from decode: valid_in 1; opcode_in 6; ALU_control_in 6; shamt_in 5; immediate_in 16; rs_in, rt_in, rd_in 5 each; rsValue_in, rtValue_in 32 each, all register-file read values.
REQ-004 SHALL have forwarding inputs: exmem_RegWrite 1; exmem_dest 5; exmem_result 32; memwb_RegWrite 1; memwb_dest 5; memwb_result 32.
REQ-005 SHALL have input branch_taken 1: Branch from the execution unit, qualified by ex_valid.
REQ-006 SHALL have outputs to the execution unit: opcode 6; ALU_control 6; shamt 5; immediate 16; rsValue 32; rtValue 32 (forwarded).
REQ-007 SHALL have outputs: ex_valid 1; ex_RegWrite 1; ex_MemRead 1; ex_MemWrite 1; ex_dest 5; ex_done 1 (EX result valid for EX/MEM capture this cycle); stall 1 (hold PC and IF/ID).

Function
REQ-008 SHALL decode at capture: R-type (opcode 0) writes rd; LW (1) MemRead, writes rt; SW (2) MemWrite; ADDI (8) writes rt; BEQ (3) and unknown opcodes write nothing; dest 0 forces ex_RegWrite 0.
REQ-009 SHALL assert stall combinationally when FSM is MUL_WAIT, or on load-use: ex_valid & ex_MemRead & valid_in & ex_dest!=0 & (rs_in==ex_dest | rt_in==ex_dest); BEQ/SW/R-type check rs and rt, LW/ADDI check rs only.
REQ-010 SHALL update the register each edge by priority: branch_taken -> load bubble (ex_valid 0, all controls 0); MUL_WAIT not expiring -> hold contents; load-use -> load bubble; else capture decode inputs with ex_valid=valid_in.
REQ-011 SHALL forward rsValue combinationally from registered rs: exmem_result if exmem_RegWrite & exmem_dest==rs & rs!=0; else memwb_result if memwb_RegWrite & memwb_dest==rs & rs!=0; else latched value; rtValue identically.
REQ-012 SHALL run FSM IDLE/MUL_WAIT: IDLE -> MUL_WAIT when a valid R-type with ALU_control 3 is captured and MUL_LAT>1, loading counter with MUL_LAT-1; counter decrements each cycle; MUL_WAIT -> IDLE when counter reaches 1.
REQ-013 SHALL assert ex_done = ex_valid & (FSM IDLE, or MUL_WAIT with counter 1); one pulse per instruction; MUL_LAT=1 gives no hold.
REQ-014 SHALL keep forwarding live during MUL_WAIT so a held multiply sees results retiring behind it.
REQ-015 SHALL, on branch_taken during MUL_WAIT, abort to IDLE, clear counter, load bubble, deassert stall next cycle.
REQ-016 SHALL never forward from register 0; rsValue/rtValue for rs/rt 0 equal latched input values.

Reset
REQ-017 SHALL, while rst_n low at a rising edge, clear ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_dest, opcode, ALU_control, shamt, immediate and latched values to 0, FSM to IDLE, counter to 0; stall and ex_done read 0 the following cycle.
REQ-018 SHALL let reset override every other event, including MUL_WAIT mid-count and simultaneous branch_taken.

Structure
REQ-019 SHALL take opcode constants (OP_RTYPE 0, OP_LW 1, OP_SW 2, OP_BEQ 3, OP_ADDI 8), ALU_control constants (ADD 1, SUB 2, MUL 3, AND 4) and FSM state type from shared package pipe_pkg.
REQ-020 SHALL implement the forwarding select in sub-module fwd_mux, instantiated once for rs and once for rt.

Verification
REQ-021 Reset: rst_n low 2 cycles mid-MUL_WAIT -> all outputs 0, FSM IDLE, stall 0 after release.
REQ-022 Load-use: LW r5 in EX, decode ADD r6,r5,r2 -> stall 1 one cycle, bubble (ex_valid 0), ADD captured next cycle, rsValue = memwb_result 0x0000_00AA.
REQ-023 Forward priority: rs=4, exmem_dest=4 result 0x11, memwb_dest=4 result 0x22 -> rsValue 0x11; exmem_RegWrite 0 -> 0x22; rs=0 -> latched value.
REQ-024 Multiply, MUL_LAT=3: MUL captured -> stall 1 two cycles, ex_done 0,0,1, next instruction captured on cycle 3.
REQ-025 Flush: branch_taken with valid ADDI at decode -> next cycle ex_valid 0, ex_RegWrite 0, stall 0.
REQ-026 Flush vs load-use: branch_taken and load-use same cycle -> bubble, stall 1 only that cycle, no duplicate capture.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID/EX stage.
// Opcodes, ALU controls, FSM state type and the ID/EX register bundle.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd1;
  localparam logic [5:0] OP_SW    = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd3;
  localparam logic [5:0] OP_ADDI  = 6'd8;

  localparam logic [5:0] ALU_ADD = 6'd1;
  localparam logic [5:0] ALU_SUB = 6'd2;
  localparam logic [5:0] ALU_MUL = 6'd3;
  localparam logic [5:0] ALU_AND = 6'd4;

  typedef logic [0:0] fsm_t;
  localparam fsm_t ST_IDLE     = 1'b0;
  localparam fsm_t ST_MUL_WAIT = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [4:0]  dest;
    logic [5:0]  opcode;
    logic [5:0]  aluc;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rsval;
    logic [31:0] rtval;
  } id_ex_t;

  function automatic logic is_mul(
    input logic [5:0] op,
    input logic [5:0] aluc
  );
    return (op == OP_RTYPE) && (aluc == ALU_MUL);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bundle: decode fields in, EX controls and stall out.
interface id_ex_stage_if;

  logic        valid_in;
  logic [5:0]  opcode_in;
  logic [5:0]  ALU_control_in;
  logic [4:0]  shamt_in;
  logic [15:0] immediate_in;
  logic [4:0]  rs_in;
  logic [4:0]  rt_in;
  logic [4:0]  rd_in;
  logic [31:0] rsValue_in;
  logic [31:0] rtValue_in;

  logic [5:0]  opcode;
  logic [5:0]  ALU_control;
  logic [4:0]  shamt;
  logic [15:0] immediate;
  logic [31:0] rsValue;
  logic [31:0] rtValue;
  logic        ex_valid;
  logic        ex_RegWrite;
  logic        ex_MemRead;
  logic        ex_MemWrite;
  logic [4:0]  ex_dest;
  logic        ex_done;
  logic        stall;

  modport master (
    output valid_in, opcode_in, ALU_control_in, shamt_in,
    output immediate_in, rs_in, rt_in, rd_in,
    output rsValue_in, rtValue_in,
    input  opcode, ALU_control, shamt, immediate,
    input  rsValue, rtValue, ex_valid, ex_RegWrite,
    input  ex_MemRead, ex_MemWrite, ex_dest, ex_done, stall
  );

  modport slave (
    input  valid_in, opcode_in, ALU_control_in, shamt_in,
    input  immediate_in, rs_in, rt_in, rd_in,
    input  rsValue_in, rtValue_in,
    output opcode, ALU_control, shamt, immediate,
    output rsValue, rtValue, ex_valid, ex_RegWrite,
    output ex_MemRead, ex_MemWrite, ex_dest, ex_done, stall
  );

endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding select: EX/MEM beats MEM/WB, register 0 never forwards.
module fwd_mux (
  input  logic [4:0]  src_i,
  input  logic [31:0] val_i,
  input  logic        exmem_we_i,
  input  logic [4:0]  exmem_dest_i,
  input  logic [31:0] exmem_res_i,
  input  logic        memwb_we_i,
  input  logic [4:0]  memwb_dest_i,
  input  logic [31:0] memwb_res_i,
  output logic [31:0] val_o
);

  always_comb begin
    val_o = val_i;
    if (src_i != 5'd0) begin
      if (exmem_we_i && exmem_dest_i == src_i)
        val_o = exmem_res_i;
      else if (memwb_we_i && memwb_dest_i == src_i)
        val_o = memwb_res_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and multi-cycle multiply stalls,
// branch flush and operand forwarding.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  dif,
  input  logic          exmem_RegWrite,
  input  logic [4:0]    exmem_dest,
  input  logic [31:0]   exmem_result,
  input  logic          memwb_RegWrite,
  input  logic [4:0]    memwb_dest,
  input  logic [31:0]   memwb_result,
  input  logic          branch_taken
);

  localparam bit MUL_HOLD = (MUL_LAT > 1);
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  id_ex_t     ex_q, ex_d, dec;
  fsm_t       state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wr, use_rt, load_use;
  logic       mul_wait, expiring, mul_start;

  always_comb begin
    dec       = '0;
    wr        = 1'b0;
    dec.valid = dif.valid_in;
    dec.opcode = dif.opcode_in;
    dec.aluc  = dif.ALU_control_in;
    dec.shamt = dif.shamt_in;
    dec.imm   = dif.immediate_in;
    dec.rs    = dif.rs_in;
    dec.rt    = dif.rt_in;
    dec.rsval = dif.rsValue_in;
    dec.rtval = dif.rtValue_in;
    unique case (dif.opcode_in)
      OP_RTYPE: begin
        wr       = 1'b1;
        dec.dest = dif.rd_in;
      end
      OP_LW: begin
        wr          = 1'b1;
        dec.memread = 1'b1;
        dec.dest    = dif.rt_in;
      end
      OP_SW:   dec.memwrite = 1'b1;
      OP_ADDI: begin
        wr       = 1'b1;
        dec.dest = dif.rt_in;
      end
      default: ;
    endcase
    // Invalid slots and writes to r0 must not look like producers.
    dec.regwrite = wr & dif.valid_in & (dec.dest != 5'd0);
    dec.memread  = dec.memread & dif.valid_in;
    dec.memwrite = dec.memwrite & dif.valid_in;
  end

  assign use_rt = !(dif.opcode_in == OP_LW ||
                    dif.opcode_in == OP_ADDI);

  assign load_use = ex_q.valid & ex_q.memread & dif.valid_in &
                    (ex_q.dest != 5'd0) &
                    ((dif.rs_in == ex_q.dest) |
                     (use_rt & (dif.rt_in == ex_q.dest)));

  assign mul_wait  = (state_q == ST_MUL_WAIT);
  assign expiring  = (cnt_q == 4'd1);
  assign mul_start = MUL_HOLD & dec.valid &
                     is_mul(dec.opcode, dec.aluc);

  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (branch_taken) begin
      ex_d    = '0;
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else if (mul_wait && !expiring) begin
      cnt_d = cnt_q - 4'd1;
    end else if (load_use) begin
      ex_d    = '0;
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else begin
      ex_d    = dec;
      state_d = mul_start ? ST_MUL_WAIT : ST_IDLE;
      cnt_d   = mul_start ? MUL_CNT : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  fwd_mux u_fwd_rs (
    .src_i        (ex_q.rs),
    .val_i        (ex_q.rsval),
    .exmem_we_i   (exmem_RegWrite),
    .exmem_dest_i (exmem_dest),
    .exmem_res_i  (exmem_result),
    .memwb_we_i   (memwb_RegWrite),
    .memwb_dest_i (memwb_dest),
    .memwb_res_i  (memwb_result),
    .val_o        (dif.rsValue)
  );

  fwd_mux u_fwd_rt (
    .src_i        (ex_q.rt),
    .val_i        (ex_q.rtval),
    .exmem_we_i   (exmem_RegWrite),
    .exmem_dest_i (exmem_dest),
    .exmem_res_i  (exmem_result),
    .memwb_we_i   (memwb_RegWrite),
    .memwb_dest_i (memwb_dest),
    .memwb_res_i  (memwb_result),
    .val_o        (dif.rtValue)
  );

  assign dif.opcode      = ex_q.opcode;
  assign dif.ALU_control = ex_q.aluc;
  assign dif.shamt       = ex_q.shamt;
  assign dif.immediate   = ex_q.imm;
  assign dif.ex_valid    = ex_q.valid;
  assign dif.ex_RegWrite = ex_q.regwrite;
  assign dif.ex_MemRead  = ex_q.memread;
  assign dif.ex_MemWrite = ex_q.memwrite;
  assign dif.ex_dest     = ex_q.dest;
  assign dif.stall       = mul_wait | load_use;
  assign dif.ex_done     = ex_q.valid & (!mul_wait | expiring);

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode table plus stall/flush/reset sequences.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        xw, ww, br;
  logic [4:0]  xd, wd;
  logic [31:0] xr, wr;
  int          checks;
  int          errors;

  id_ex_stage_if dif ();

  id_ex_stage #(.MUL_LAT(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dif            (dif),
    .exmem_RegWrite (xw),
    .exmem_dest     (xd),
    .exmem_result   (xr),
    .memwb_RegWrite (ww),
    .memwb_dest     (wd),
    .memwb_result   (wr),
    .branch_taken   (br)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [5:0]  op;
    logic [5:0]  alu;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] rsv, rtv;
    logic        xw;
    logic [4:0]  xd;
    logic [31:0] xr;
    logic        ww;
    logic [4:0]  wd;
    logic [31:0] wr;
    logic        e_v, e_rw, e_mr, e_mw;
    logic [4:0]  e_dest;
    logic [31:0] e_rs, e_rt;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [5:0] op,
                         input logic [5:0] alu, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsv, input logic [31:0] rtv);
    dif.valid_in       = v;
    dif.opcode_in      = op;
    dif.ALU_control_in = alu;
    dif.shamt_in       = 5'd0;
    dif.immediate_in   = 16'h0;
    dif.rs_in          = rs;
    dif.rt_in          = rt;
    dif.rd_in          = rd;
    dif.rsValue_in     = rsv;
    dif.rtValue_in     = rtv;
  endtask

  task automatic set_fwd(input logic a, input logic [4:0] ad,
                         input logic [31:0] ar, input logic b,
                         input logic [4:0] bd, input logic [31:0] bv);
    xw = a; xd = ad; xr = ar;
    ww = b; wd = bd; wr = bv;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    br     = 1'b0;
    rst_n  = 1'b0;
    set_fwd(0, 0, 0, 0, 0, 0);
    set_dec(0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);

    //            v op    alu rs rt rd imm  rsv    rtv     xw xd xr   ww wd wr
    tbl[0]  = '{1, 6'd0, 6'd1, 1, 2, 3, 16'h0, 32'h100, 32'h200,
                0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3, 32'h100, 32'h200};
    tbl[1]  = '{1, 6'd1, 6'd1, 1, 7, 0, 16'h4, 32'h10, 32'h20,
                0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 7, 32'h10, 32'h20};
    tbl[2]  = '{1, 6'd2, 6'd1, 2, 3, 0, 16'h8, 32'h5, 32'h6,
                0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'h5, 32'h6};
    tbl[3]  = '{1, 6'd8, 6'd1, 1, 0, 0, 16'h1, 32'h7, 32'h8,
                0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h7, 32'h8};
    tbl[4]  = '{1, 6'd3, 6'd2, 1, 2, 0, 16'hFFFC, 32'h9, 32'hA,
                0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h9, 32'hA};
    tbl[5]  = '{1, 6'h3F, 6'd1, 1, 2, 3, 16'h0, 32'hB, 32'hC,
                0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hB, 32'hC};
    tbl[6]  = '{1, 6'd0, 6'd4, 1, 2, 0, 16'h0, 32'hD, 32'hE,
                0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hD, 32'hE};
    tbl[7]  = '{1, 6'd0, 6'd1, 4, 5, 6, 16'h0, 32'h99, 32'h55,
                1, 4, 32'h11, 1, 4, 32'h22, 1, 1, 0, 0, 6, 32'h11, 32'h55};
    tbl[8]  = '{1, 6'd0, 6'd1, 4, 5, 6, 16'h0, 32'h99, 32'h55,
                0, 4, 32'h11, 1, 4, 32'h22, 1, 1, 0, 0, 6, 32'h22, 32'h55};
    tbl[9]  = '{1, 6'd0, 6'd1, 0, 0, 6, 16'h0, 32'h33, 32'h44,
                1, 0, 32'h11, 1, 0, 32'h22, 1, 1, 0, 0, 6, 32'h33, 32'h44};
    tbl[10] = '{1, 6'd0, 6'd2, 3, 9, 6, 16'h0, 32'h1, 32'h2,
                0, 9, 32'h11, 1, 9, 32'hBEEF, 1, 1, 0, 0, 6, 32'h1, 32'hBEEF};
    tbl[11] = '{0, 6'd0, 6'd1, 1, 2, 3, 16'h0, 32'h1, 32'h2,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h1, 32'h2};

    tick();
    tick();
    chk("rst ex_valid", {31'b0, dif.ex_valid}, 0);
    chk("rst stall", {31'b0, dif.stall}, 0);
    chk("rst ex_done", {31'b0, dif.ex_done}, 0);
    chk("rst rsValue", dif.rsValue, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      set_dec(tbl[i].v, tbl[i].op, tbl[i].alu, tbl[i].rs,
              tbl[i].rt, tbl[i].rd, tbl[i].rsv, tbl[i].rtv);
      dif.immediate_in = tbl[i].imm;
      set_fwd(tbl[i].xw, tbl[i].xd, tbl[i].xr,
              tbl[i].ww, tbl[i].wd, tbl[i].wr);
      tick();
      chk($sformatf("v%0d ex_valid", i), {31'b0, dif.ex_valid}, {31'b0, tbl[i].e_v});
      chk($sformatf("v%0d RegWrite", i), {31'b0, dif.ex_RegWrite}, {31'b0, tbl[i].e_rw});
      chk($sformatf("v%0d MemRead", i), {31'b0, dif.ex_MemRead}, {31'b0, tbl[i].e_mr});
      chk($sformatf("v%0d MemWrite", i), {31'b0, dif.ex_MemWrite}, {31'b0, tbl[i].e_mw});
      if (tbl[i].e_rw)
        chk($sformatf("v%0d dest", i), {27'b0, dif.ex_dest}, {27'b0, tbl[i].e_dest});
      chk($sformatf("v%0d rsValue", i), dif.rsValue, tbl[i].e_rs);
      chk($sformatf("v%0d rtValue", i), dif.rtValue, tbl[i].e_rt);
      chk($sformatf("v%0d imm", i), {16'b0, dif.immediate}, {16'b0, tbl[i].imm});
      chk($sformatf("v%0d ex_done", i), {31'b0, dif.ex_done}, {31'b0, tbl[i].e_v});
    end

    // load-use: LW r5 then ADD r6,r5,r2
    set_fwd(0, 0, 0, 0, 0, 0);
    set_dec(1, 6'd1, 6'd1, 5'd1, 5'd5, 5'd0, 32'h0, 32'h0);
    tick();
    chk("lu lw stall", {31'b0, dif.stall}, 0);
    set_dec(1, 6'd0, 6'd1, 5'd5, 5'd2, 5'd6, 32'h0, 32'h3);
    #1;
    chk("lu stall", {31'b0, dif.stall}, 1);
    tick();
    chk("lu bubble", {31'b0, dif.ex_valid}, 0);
    chk("lu stall clr", {31'b0, dif.stall}, 0);
    set_fwd(0, 0, 0, 1, 5, 32'hAA);
    tick();
    chk("lu add valid", {31'b0, dif.ex_valid}, 1);
    chk("lu add dest", {27'b0, dif.ex_dest}, 6);
    chk("lu add rs", dif.rsValue, 32'hAA);

    // multiply, MUL_LAT=3
    set_fwd(0, 0, 0, 0, 0, 0);
    set_dec(0, 6'd0, 6'd1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    set_dec(1, 6'd0, 6'd3, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2);
    #1;
    chk("mul c0 done", {31'b0, dif.ex_done}, 0);
    tick();
    set_dec(1, 6'd0, 6'd1, 5'd1, 5'd2, 5'd9, 32'h1, 32'h2);
    #1;
    chk("mul c1 stall", {31'b0, dif.stall}, 1);
    chk("mul c1 done", {31'b0, dif.ex_done}, 0);
    chk("mul c1 alu", {26'b0, dif.ALU_control}, 3);
    tick();
    set_fwd(1, 1, 32'h77, 0, 0, 0);
    #1;
    chk("mul c2 stall", {31'b0, dif.stall}, 1);
    chk("mul c2 done", {31'b0, dif.ex_done}, 1);
    chk("mul c2 dest", {27'b0, dif.ex_dest}, 8);
    chk("mul c2 fwd", dif.rsValue, 32'h77);
    tick();
    chk("mul c3 dest", {27'b0, dif.ex_dest}, 9);
    chk("mul c3 stall", {31'b0, dif.stall}, 0);
    chk("mul c3 done", {31'b0, dif.ex_done}, 1);

    // branch during MUL_WAIT
    set_fwd(0, 0, 0, 0, 0, 0);
    set_dec(1, 6'd0, 6'd3, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2);
    tick();
    chk("mbr stall", {31'b0, dif.stall}, 1);
    br = 1'b1;
    set_dec(0, 6'd0, 6'd1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    br = 1'b0;
    #1;
    chk("mbr valid", {31'b0, dif.ex_valid}, 0);
    chk("mbr stall", {31'b0, dif.stall}, 0);
    chk("mbr done", {31'b0, dif.ex_done}, 0);

    // flush with ADDI at decode
    set_dec(1, 6'd8, 6'd1, 5'd1, 5'd4, 5'd0, 32'h1, 32'h2);
    br = 1'b1;
    tick();
    br = 1'b0;
    #1;
    chk("fl valid", {31'b0, dif.ex_valid}, 0);
    chk("fl regwrite", {31'b0, dif.ex_RegWrite}, 0);
    chk("fl stall", {31'b0, dif.stall}, 0);

    // flush and load-use in the same cycle
    set_dec(1, 6'd1, 6'd1, 5'd1, 5'd5, 5'd0, 32'h0, 32'h0);
    tick();
    set_dec(1, 6'd0, 6'd1, 5'd5, 5'd2, 5'd6, 32'h0, 32'h0);
    br = 1'b1;
    #1;
    chk("fll stall", {31'b0, dif.stall}, 1);
    tick();
    br = 1'b0;
    set_dec(0, 6'd0, 6'd1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    chk("fll bubble", {31'b0, dif.ex_valid}, 0);
    chk("fll stall clr", {31'b0, dif.stall}, 0);
    tick();
    chk("fll no dup", {31'b0, dif.ex_valid}, 0);

    // reset mid-MUL_WAIT with a simultaneous branch
    set_dec(1, 6'd0, 6'd3, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2);
    tick();
    rst_n = 1'b0;
    br    = 1'b1;
    tick();
    tick();
    chk("mrst valid", {31'b0, dif.ex_valid}, 0);
    chk("mrst alu", {26'b0, dif.ALU_control}, 0);
    chk("mrst dest", {27'b0, dif.ex_dest}, 0);
    chk("mrst rs", dif.rsValue, 0);
    rst_n = 1'b1;
    br    = 1'b0;
    set_dec(0, 6'd0, 6'd1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    chk("mrst stall", {31'b0, dif.stall}, 0);
    chk("mrst done", {31'b0, dif.ex_done}, 0);
    tick();
    chk("mrst post stall", {31'b0, dif.stall}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
